// File: rtl/synth_sysex_pkg.sv
// Shared definitions for the sysex patch dumper: FSM state encoding and
// the fixed framing bytes of the dump stream.
package synth_sysex_pkg;

    typedef enum logic [3:0] {
        IDLE, HDR, SEL, RD_HI, RD_SMP, RD_LO, SEND, CSUM, EOX, FIN
    } dump_state_t;

    localparam logic [7:0] SYSEX_SOX = 8'hF0;
    localparam logic [7:0] SYSEX_EOX = 8'hF7;
    localparam logic [7:0] CMD_DUMP  = 8'h01;

endpackage

// File: rtl/sysex_tx_reg.sv
// One-byte valid/ready holding register feeding the MIDI transmitter.
// A load takes priority over the drain, so a new byte may follow a transfer.
module sysex_tx_reg (
    input  logic       sCLK_XVXOSC,
    input  logic       reset_reg_N,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic       xfer
);

    assign xfer = tx_valid & tx_ready;

    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            tx_byte  <= 8'h00;
            tx_valid <= 1'b0;
        end else if (load) begin
            tx_byte  <= load_byte;
            tx_valid <= 1'b1;
        end else if (xfer) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sysex_patch_dumper.sv
// Reads every oscillator and common parameter over the parameter bus and
// streams them out as one sysex dump. Define SYSEX_CHECKSUM_EN to append a
// 7-bit checksum byte before F7.
//
// state  | meaning
// IDLE   | waiting for dump_req
// HDR    | sending F0, manufacturer id, dump command
// SEL    | address and page select set up, read low
// RD_HI  | read strobe high, slave latches
// RD_SMP | read high, data sampled and queued for transmit
// RD_LO  | read low, address and select still held
// SEND   | parameter byte waiting for the transmitter
// CSUM   | checksum byte waiting for the transmitter
// EOX    | F7 waiting for the transmitter
// FIN    | done pulse
module sysex_patch_dumper
    import synth_sysex_pkg::*;
#(
    parameter int         V_OSC    = 4,
    parameter int         OSC_ADRS = 16,
    parameter int         COM_ADRS = 16,
    parameter logic [7:0] MANUF_ID = 8'h7D
) (
    input  logic       sCLK_XVXOSC,
    input  logic       reset_reg_N,
    input  logic       dump_req,
    input  logic [7:0] data,
    output logic [6:0] adr,
    output logic       read,
    output logic       osc_sel,
    output logic       com_sel,
    output logic       sysex_data_patch_send,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    dump_state_t state;
    logic [1:0]  hdr_cnt;
    logic [6:0]  osc_cnt, idx_cnt;
    logic        in_com;
    logic [6:0]  nxt_osc, nxt_idx, nxt_adr;
    logic        nxt_com, last_addr;
    logic        load, xfer;
    logic [7:0]  load_byte;
`ifdef SYSEX_CHECKSUM_EN
    logic [6:0]  csum;
`endif

    sysex_tx_reg u_tx_reg (
        .sCLK_XVXOSC (sCLK_XVXOSC),
        .reset_reg_N (reset_reg_N),
        .load        (load),
        .load_byte   (load_byte),
        .tx_ready    (tx_ready),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .xfer        (xfer)
    );

    // Walk oscillator pages first, then the common page.
    always_comb begin
        nxt_idx   = idx_cnt + 7'd1;
        nxt_osc   = osc_cnt;
        nxt_com   = in_com;
        last_addr = 1'b0;
        if (!in_com) begin
            if (idx_cnt == 7'(OSC_ADRS - 1)) begin
                nxt_idx = 7'd0;
                if (osc_cnt == 7'(V_OSC - 1))
                    nxt_com = 1'b1;
                else
                    nxt_osc = osc_cnt + 7'd1;
            end
        end else if (idx_cnt == 7'(COM_ADRS - 1)) begin
            nxt_idx   = 7'd0;
            last_addr = 1'b1;
        end
        nxt_adr = nxt_com ? nxt_idx : ((nxt_osc << 4) + nxt_idx);
    end

    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state                 <= IDLE;
            adr                   <= 7'd0;
            read                  <= 1'b0;
            osc_sel               <= 1'b0;
            com_sel               <= 1'b0;
            sysex_data_patch_send <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            load                  <= 1'b0;
            load_byte             <= 8'h00;
            hdr_cnt               <= 2'd0;
            osc_cnt               <= 7'd0;
            idx_cnt               <= 7'd0;
            in_com                <= 1'b0;
`ifdef SYSEX_CHECKSUM_EN
            csum                  <= 7'd0;
`endif
        end else begin
            load <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (dump_req) begin
                    state                 <= HDR;
                    busy                  <= 1'b1;
                    sysex_data_patch_send <= 1'b1;
                    load                  <= 1'b1;
                    load_byte             <= SYSEX_SOX;
                    hdr_cnt               <= 2'd0;
                    osc_cnt               <= 7'd0;
                    idx_cnt               <= 7'd0;
                    in_com                <= 1'b0;
`ifdef SYSEX_CHECKSUM_EN
                    csum                  <= 7'd0;
`endif
                end
                HDR: if (xfer) begin
                    if (hdr_cnt == 2'd2) begin
                        state   <= SEL;
                        adr     <= 7'd0;
                        osc_sel <= 1'b1;
                        com_sel <= 1'b0;
                    end else begin
                        load      <= 1'b1;
                        load_byte <= (hdr_cnt == 2'd0) ? MANUF_ID : CMD_DUMP;
                        hdr_cnt   <= hdr_cnt + 2'd1;
                    end
                end
                SEL: begin
                    state <= RD_HI;
                    read  <= 1'b1;
                end
                RD_HI: state <= RD_SMP;
                // The masked byte goes straight into the holding register so it
                // becomes valid exactly when SEND is entered.
                RD_SMP: begin
                    state     <= RD_LO;
                    read      <= 1'b0;
                    load      <= 1'b1;
                    load_byte <= data & 8'h7F;
`ifdef SYSEX_CHECKSUM_EN
                    csum      <= csum + data[6:0];
`endif
                end
                RD_LO: begin
                    state   <= SEND;
                    osc_sel <= 1'b0;
                    com_sel <= 1'b0;
                end
                SEND: if (xfer) begin
                    if (last_addr) begin
                        load <= 1'b1;
`ifdef SYSEX_CHECKSUM_EN
                        state     <= CSUM;
                        load_byte <= {1'b0, 7'd0 - csum};
`else
                        state     <= EOX;
                        load_byte <= SYSEX_EOX;
`endif
                    end else begin
                        state   <= SEL;
                        idx_cnt <= nxt_idx;
                        osc_cnt <= nxt_osc;
                        in_com  <= nxt_com;
                        adr     <= nxt_adr;
                        osc_sel <= ~nxt_com;
                        com_sel <= nxt_com;
                    end
                end
                CSUM: begin
`ifdef SYSEX_CHECKSUM_EN
                    if (xfer) begin
                        state     <= EOX;
                        load      <= 1'b1;
                        load_byte <= SYSEX_EOX;
                    end
`else
                    state <= IDLE;
`endif
                end
                EOX: if (xfer) begin
                    state                 <= FIN;
                    busy                  <= 1'b0;
                    sysex_data_patch_send <= 1'b0;
                    done                  <= 1'b1;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sysex_patch_dumper.md
SYSEX_PATCH_DUMPER -- requirements
Module: sysex_patch_dumper

Interface
REQ-001 SHALL have parameter V_OSC, default 4, number of oscillator parameter pages.
REQ-002 SHALL have parameter OSC_ADRS, default 16, number of addresses per oscillator page.
REQ-003 SHALL have parameter COM_ADRS, default 16, number of common-page addresses.
REQ-004 SHALL have parameter MANUF_ID, default 8'h7D, sysex manufacturer byte.
REQ-005 SHALL have port sCLK_XVXOSC, input, 1, system clock.
REQ-006 SHALL have port reset_reg_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port dump_req, input, 1, single-cycle dump start request.
REQ-008 SHALL have port data, input, 8, parameter bus read data driven by the slaves.
REQ-009 SHALL have port adr, output, 7, parameter bus address.
REQ-010 SHALL have port read, output, 1, read strobe; slaves latch on its rising edge.
REQ-011 SHALL have ports osc_sel and com_sel, outputs, 1 each, page selects.
REQ-012 SHALL have port sysex_data_patch_send, output, 1, slave data-drive enable; high for the whole dump.
REQ-013 SHALL have ports tx_byte (output, 8), tx_valid (output, 1) and tx_ready (input, 1), the MIDI transmitter byte stream.
REQ-014 SHALL have ports busy (output, 1) and done (output, 1), where done is a one-cycle completion pulse.

Function
REQ-015 SHALL emit F0, MANUF_ID, 01, then V_OSC*OSC_ADRS oscillator bytes, then COM_ADRS common bytes, then F7 in that order, 84 bytes at default parameters.
REQ-016 SHALL order oscillator bytes by address adr = (osc<<4)+i, with osc_sel=1, for osc from 0 to V_OSC-1 and i from 0 to OSC_ADRS-1.
REQ-017 SHALL read common bytes at adr = i, with com_sel=1, for i from 0 to COM_ADRS-1; osc_sel and com_sel are never high together.
REQ-018 SHALL use FSM states IDLE, HDR, SEL, RD_HI, RD_SMP, RD_LO, SEND, CSUM, EOX, FIN.
REQ-019 SHALL run the FSM as follows: IDLE goes to HDR on dump_req; HDR sends 3 bytes and goes to SEL; the read sequence is SEL, RD_HI, RD_SMP, RD_LO, SEND; SEND goes to SEL if addresses remain, else to CSUM/EOX; EOX goes to FIN; FIN goes to IDLE.
REQ-020 SHALL set adr and select in SEL, one cycle of setup before read rises.
REQ-021 SHALL hold read=1 in RD_HI and RD_SMP, and read=0 in all other states.
REQ-022 SHALL sample data in RD_SMP, store data & 8'h7F, and hold adr and select stable through RD_LO.
REQ-023 SHALL keep tx_byte stable while tx_valid=1 and tx_ready=0; a byte transfers on a clock edge with tx_valid & tx_ready.
REQ-024 SHALL advance out of SEND, HDR or EOX only after each byte has transferred.
REQ-025 SHALL keep tx_valid deasserted in SEL through RD_LO.
REQ-026 SHALL keep busy=1 and sysex_data_patch_send=1 from HDR through EOX.
REQ-027 SHALL pulse done in FIN.
REQ-028 SHALL ignore dump_req when not in IDLE, with no queuing.
REQ-029 SHALL wait indefinitely, with no timeout, while tx_ready=0.

Reset
REQ-030 SHALL reset asynchronously on reset_reg_N low, which forces IDLE with adr=0, read=0, osc_sel=0, com_sel=0, sysex_data_patch_send=0, tx_valid=0, tx_byte=0, busy=0, done=0, and all counters and the checksum at 0.
REQ-031 SHALL abort a dump on reset mid-dump without emitting F7; the next dump_req starts a fresh stream.

Configuration
REQ-032 SHALL, when SYSEX_CHECKSUM_EN is defined, include the CSUM state, which sends (128 - (sum of parameter bytes mod 128)) mod 128 before F7, making 85 bytes at default parameters.
REQ-033 SHALL, when SYSEX_CHECKSUM_EN is undefined, send F7 directly after the last parameter byte and omit the accumulator logic.

Structure
REQ-034 SHALL place the state enum, SYSEX_SOX=8'hF0, SYSEX_EOX=8'hF7 and CMD_DUMP=8'h01 in shared package synth_sysex_pkg.
REQ-035 SHALL contain one sub-module, sysex_tx_reg, a one-byte valid/ready output holding register; the address sequencing stays in the top module.

Verification
REQ-036 SHALL verify that dump_req with a slave model returning (adr ^ 8'h2A) and tx_ready=1 yields 84 bytes: F0, 7D, 01, 2A, 2B, ..., then F7.
REQ-037 SHALL verify that a slave returning 8'hC0 at adr 0x10 produces stream byte 4+16, counting the first stream byte as 1, equal to 8'h40 (masked).
REQ-038 SHALL verify that random tx_ready backpressure, at 30% ready, leaves tx_byte unchanged while valid and not ready, and that the byte sequence is identical to REQ-036.
REQ-039 SHALL verify that reset_reg_N pulsed low at byte 40 drops busy, read and sysex_data_patch_send immediately, sends no F7, and that a following dump_req produces a complete 84-byte stream.
REQ-040 SHALL verify that dump_req pulsed again while busy=1 produces exactly one stream and one done pulse.
REQ-041 SHALL verify that, with SYSEX_CHECKSUM_EN defined and all parameter bytes 8'h01, the 80 bytes summing to 80 produce checksum 8'h30 followed by F7, 85 bytes total.
